// File: rtl/imem_pkg.sv
// imem_pkg: shared constants, instruction type and boot program for the instruction memory
package imem_pkg;

    localparam int INSTR_W  = 32;
    localparam int BOOT_LEN = 5;

    typedef logic [INSTR_W-1:0] instr_t;

    localparam instr_t BOOT_PROG [BOOT_LEN] = '{
        32'h2008_0005,
        32'h2009_000A,
        32'h0109_5020,
        32'hAC0A_0000,
        32'h8C0B_0000
    };

endpackage

// File: rtl/imem_boot_rom.sv
// imem_boot_rom: combinational boot-program lookup by word index, zero beyond the program
module imem_boot_rom
    import imem_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic [IDX_W-1:0] idx,
    output instr_t           word
);

    // match the index against each boot slot; anything past the program reads as zero
    always_comb begin
        word = '0;
        for (int i = 0; i < BOOT_LEN; i++)
            if (idx == IDX_W'(i)) word = BOOT_PROG[i];
    end

endmodule

// File: rtl/instruction_memory.sv
// instruction_memory: word-organised instruction store with boot load and combinational fetch
// Optional macro IMEM_PROG_PORT_EN adds a single-word write port (prog_we/prog_addr/prog_data).
module instruction_memory
    import imem_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              startin,
    input  logic [ADDR_W-1:0] address,
`ifdef IMEM_PROG_PORT_EN
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
`endif
    output logic [DATA_W-1:0] instruction
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WI_W  = ADDR_W - 2;

    logic [WI_W-1:0] rd_idx;
    instr_t          words [DEPTH];
    logic            unused_lsbs;

    assign rd_idx = address[ADDR_W-1:2];

`ifdef IMEM_PROG_PORT_EN
    logic [WI_W-1:0] wr_idx;
    assign wr_idx      = prog_addr[ADDR_W-1:2];
    assign unused_lsbs = ^{address[1:0], prog_addr[1:0]};
`else
    assign unused_lsbs = ^address[1:0];
`endif

    for (genvar g = 0; g < DEPTH; g++) begin : g_word
        instr_t boot_w;
        instr_t word_q;

        imem_boot_rom #(.IDX_W(IDX_W)) u_rom (
            .idx  (IDX_W'(g)),
            .word (boot_w)
        );

        // each word clears on reset, takes its boot value on load, else holds (or takes a prog write)
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                word_q <= '0;
            else if (startin)
                word_q <= boot_w;
`ifdef IMEM_PROG_PORT_EN
            else if (prog_we && wr_idx == WI_W'(g))
                word_q <= instr_t'(prog_data);
`endif
        end

        assign words[g] = word_q;
    end

    // fetch is stalled to NOP during load and returns NOP beyond the array (no wrap)
    always_comb
        instruction = (startin || rd_idx >= WI_W'(DEPTH)) ? '0 : DATA_W'(words[rd_idx[IDX_W-1:0]]);

endmodule

// File: tb/tb_instruction_memory.sv
// tb_instruction_memory: table-driven, scoreboarded check of reset, load, fetch and range handling
module tb_instruction_memory;
    import imem_pkg::*;

    localparam int DEPTH = 64;

    typedef struct {
        logic [31:0] addr;
        instr_t      exp;
    } vec_t;

    logic        clk = 0;
    logic        rst_n;
    logic        startin;
    logic [31:0] address;
    logic [31:0] instruction;
`ifdef IMEM_PROG_PORT_EN
    logic        prog_we = 0;
    logic [31:0] prog_addr = '0;
    logic [31:0] prog_data = '0;
`endif

    int     errors = 0;
    int     checks = 0;
    instr_t sb [$];
    vec_t   tbl [11];
    instr_t exp_w;

    instruction_memory #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .startin     (startin),
        .address     (address),
`ifdef IMEM_PROG_PORT_EN
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
`endif
        .instruction (instruction)
    );

    always #5 clk = ~clk;

    task automatic chk(input logic [31:0] a, input instr_t e, input string nm);
        instr_t x;
        address = a;
        sb.push_back(e);
        #1;
        x = sb.pop_front();
        checks++;
        if (instruction !== x) begin
            errors++;
            $display("FAIL %s addr=%h got=%h exp=%h", nm, a, instruction, x);
        end
    endtask

    task automatic run_table(input string nm);
        for (int i = 0; i < 11; i++) chk(tbl[i].addr, tbl[i].exp, nm);
    endtask

    task automatic to_negedge();
        @(negedge clk);
    endtask

    initial begin
        tbl[0]  = '{32'd0,         32'h2008_0005};
        tbl[1]  = '{32'd4,         32'h2009_000A};
        tbl[2]  = '{32'd8,         32'h0109_5020};
        tbl[3]  = '{32'd12,        32'hAC0A_0000};
        tbl[4]  = '{32'd16,        32'h8C0B_0000};
        tbl[5]  = '{32'd6,         32'h2009_000A};
        tbl[6]  = '{32'd3,         32'h2008_0005};
        tbl[7]  = '{32'd20,        32'h0};
        tbl[8]  = '{32'd252,       32'h0};
        tbl[9]  = '{32'd256,       32'h0};
        tbl[10] = '{32'hFFFF_FFFC, 32'h0};

        rst_n   = 0;
        startin = 0;
        address = 0;
        #2;
        chk(0, 32'h0, "reset_a0");
        to_negedge();
        to_negedge();
        rst_n = 1;
        chk(8, 32'h0, "post_reset_a8");
        to_negedge();
        chk(0, 32'h0, "post_reset_a0");

        startin = 1;
        chk(0, 32'h0, "load_high_pre");
        chk(4, 32'h0, "load_high_a4");
        to_negedge();
        chk(0, 32'h0, "load_high_post");
        startin = 0;
        run_table("fetch");

        to_negedge();
        chk(8, 32'h0109_5020, "pre_reset_a8");
        rst_n = 0;
        chk(8, 32'h0, "async_reset_a8");
        chk(0, 32'h0, "async_reset_a0");
        rst_n = 1;
        to_negedge();
        chk(0, 32'h0, "after_reset_a0");
        chk(16, 32'h0, "after_reset_a16");

        startin = 1;
        to_negedge();
        rst_n = 0;
        #1;
        rst_n = 1;
        startin = 0;
        chk(0, 32'h0, "abort_load_a0");
        to_negedge();
        chk(4, 32'h0, "abort_load_a4");

        startin = 1;
        to_negedge();
        startin = 0;
        chk(0, 32'h2008_0005, "reload_a0");

        startin = 1;
        for (int k = 0; k < 5; k++) begin
            chk(32'(4 * k), 32'h0, "startin_sweep");
            to_negedge();
        end
        startin = 0;
        run_table("idempotent");

`ifdef IMEM_PROG_PORT_EN
        prog_we   = 1;
        prog_addr = 20;
        prog_data = 32'hDEAD_BEEF;
        to_negedge();
        prog_we = 0;
        chk(20, 32'hDEAD_BEEF, "prog_write_a20");
        tbl[7].exp = 32'hDEAD_BEEF;
        prog_we   = 1;
        prog_addr = 400;
        prog_data = 32'h1234_5678;
        to_negedge();
        prog_we = 0;
        chk(400, 32'h0, "prog_oob_a400");
        run_table("prog_oob_intact");
        prog_we   = 1;
        prog_addr = 0;
        prog_data = 32'hCAFE_F00D;
        startin   = 1;
        to_negedge();
        prog_we = 0;
        startin = 0;
        chk(0, 32'h2008_0005, "load_over_prog");
`endif

        exp_w = 32'h0;
        chk(32'(4 * DEPTH), exp_w, "oob_final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
